// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// operand/word widths and the default watchdog limit.
package div_arb_pkg;

    localparam int DIVIDEND_W             = 10;
    localparam int DIVISOR_W              = 5;
    localparam int WORD_W                 = 5;
    localparam int DEFAULT_TIMEOUT_CYCLES = 63;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        LOAD_DIV,
        WAIT_DONE,
        READ_REM,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       id
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        id    = 1'b0;
        case (req)
            2'b01: begin
                grant = 2'b01;
                id    = 1'b0;
            end
            2'b10: begin
                grant = 2'b10;
                id    = 1'b1;
            end
            2'b11: begin
                id    = ~last;
                grant = last ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one 10-by-5 serial divider between two requesters and returns tagged results.
// Define DIV_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog of TIMEOUT_CYCLES cycles.
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DIVIDEND_W-1:0] dividend0,
    input  logic [DIVISOR_W-1:0]  divisor0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [DIVIDEND_W-1:0] dividend1,
    input  logic [DIVISOR_W-1:0]  divisor1,
    output logic                  ack1,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [WORD_W-1:0]     rsp_quot,
    output logic [WORD_W-1:0]     rsp_rem,
    output logic                  rsp_ov,
    output logic                  rsp_dbz,
    output logic                  rsp_timeout,
    output logic                  div_start,
    output logic [WORD_W-1:0]     div_data,
    input  logic                  div_done,
    input  logic                  div_ov,
    input  logic                  div_dbz,
    input  logic [WORD_W-1:0]     div_dout
);

    state_t                state, state_next;
    logic [1:0]            grant;
    logic                  win_id;
    logic                  last_id;
    logic                  served_any;
    logic                  timeout_hit;
    logic                  op_id;
    logic [DIVIDEND_W-1:0] op_dividend;
    logic [DIVISOR_W-1:0]  op_divisor;
    logic [DIVIDEND_W-1:0] win_dividend;
    logic [DIVISOR_W-1:0]  win_divisor;
    logic [WORD_W-1:0]     quot_q;
    logic                  ov_q;
    logic                  dbz_q;

    // Until someone has been served, report requester 1 as last so requester 0 wins the first tie.
    rr_arbiter2 u_arb (
        .req   ({req1, req0}),
        .last  (served_any ? last_id : 1'b1),
        .grant (grant),
        .id    (win_id)
    );

    assign win_dividend = grant[1] ? dividend1 : dividend0;
    assign win_divisor  = grant[1] ? divisor1  : divisor0;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT_DONE) && !div_done
                         && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     wait_cnt <= '0;
        else if (state == LOAD_DIV)  wait_cnt <= '0;
        else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|grant) state_next = LOAD_HI;
            LOAD_HI:   state_next = LOAD_LO;
            LOAD_LO:   state_next = LOAD_DIV;
            LOAD_DIV:  state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (div_done)         state_next = READ_REM;
                else if (timeout_hit) state_next = RESP;
            end
            READ_REM:  state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are registered: each is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            div_start   <= 1'b0;
            div_data    <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_quot    <= '0;
            rsp_rem     <= '0;
            rsp_ov      <= 1'b0;
            rsp_dbz     <= 1'b0;
            rsp_timeout <= 1'b0;
            op_id       <= 1'b0;
            op_dividend <= '0;
            op_divisor  <= '0;
            quot_q      <= '0;
            ov_q        <= 1'b0;
            dbz_q       <= 1'b0;
            last_id     <= 1'b0;
            served_any  <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            div_start <= 1'b0;
            div_data  <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (|grant) begin
                    op_id       <= win_id;
                    op_dividend <= win_dividend;
                    op_divisor  <= win_divisor;
                    ack0        <= grant[0];
                    ack1        <= grant[1];
                    div_start   <= 1'b1;
                    div_data    <= win_dividend[DIVIDEND_W-1:WORD_W];
                end
                LOAD_HI: div_data <= op_dividend[WORD_W-1:0];
                LOAD_LO: div_data <= op_divisor;
                WAIT_DONE: begin
                    if (div_done) begin
                        quot_q <= div_dout;
                        ov_q   <= div_ov;
                        dbz_q  <= div_dbz;
                    end else if (timeout_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= op_id;
                        rsp_quot    <= '0;
                        rsp_rem     <= '0;
                        rsp_ov      <= 1'b0;
                        rsp_dbz     <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                READ_REM: begin
                    rsp_valid   <= 1'b1;
                    rsp_id      <= op_id;
                    rsp_quot    <= quot_q;
                    rsp_rem     <= div_dout;
                    rsp_ov      <= ov_q;
                    rsp_dbz     <= dbz_q;
                    rsp_timeout <= 1'b0;
                end
                RESP: begin
                    last_id    <= op_id;
                    served_any <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter: directed + randomized traffic, a behavioural
// serial-divider responder and a scoreboard of expected responses.
module tb_divider_arbiter;

    localparam int T_CYC = 8;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] dvd;
        logic [4:0] dvs;
    } op_t;

    typedef struct packed {
        logic [4:0] q;
        logic [4:0] r;
        logic       ov;
        logic       dbz;
    } div_t;

    typedef struct packed {
        logic       id;
        logic [4:0] q;
        logic [4:0] r;
        logic       ov;
        logic       dbz;
        logic       to;
        logic [7:0] lat;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [9:0] dividend0 = '0, dividend1 = '0;
    logic [4:0] divisor0 = '0, divisor1 = '0;
    logic       ack0, ack1;
    logic       rsp_valid, rsp_id, rsp_ov, rsp_dbz, rsp_timeout;
    logic [4:0] rsp_quot, rsp_rem;
    logic       div_start;
    logic [4:0] div_data;
    logic       div_done = 1'b0, div_ov = 1'b0, div_dbz = 1'b0;
    logic [4:0] div_dout = '0;

    divider_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .dividend0   (dividend0),
        .divisor0    (divisor0),
        .ack0        (ack0),
        .req1        (req1),
        .dividend1   (dividend1),
        .divisor1    (divisor1),
        .ack1        (ack1),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_quot    (rsp_quot),
        .rsp_rem     (rsp_rem),
        .rsp_ov      (rsp_ov),
        .rsp_dbz     (rsp_dbz),
        .rsp_timeout (rsp_timeout),
        .div_start   (div_start),
        .div_data    (div_data),
        .div_done    (div_done),
        .div_ov      (div_ov),
        .div_dbz     (div_dbz),
        .div_dout    (div_dout)
    );

    always #5 clk = ~clk;

    op_t        op_q0[$];
    op_t        op_q1[$];
    rsp_t       exp_q[$];
    int         grant_log[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cycle = 0;
    int         done_delay = 1;
    int         m_phase = 0;
    int         m_cnt = 0;
    int         div_cycle = 0;
    op_t        m_op = '0;
    op_t        cur_op = '0;
    logic [4:0] m_rem = '0;
    logic       have_last = 1'b0;
    logic       last_id = 1'b0;
    logic [1:0] prev_ack = 2'b00;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // What an ideal 10-by-5 divider returns; quotient wraps to 5 bits on overflow.
    function automatic div_t div_fn(input op_t op);
        div_t d;
        int   q;
        int   r;
        d = '0;
        if (op.dvs == 5'd0) begin
            d.dbz = 1'b1;
            d.q   = 5'h1f;
            d.r   = op.dvd[4:0];
        end else begin
            q    = int'(op.dvd) / int'(op.dvs);
            r    = int'(op.dvd) % int'(op.dvs);
            d.q  = q[4:0];
            d.r  = r[4:0];
            d.ov = (q > 31);
        end
        return d;
    endfunction

    // Expected response and its latency, counted from the LOAD_DIV cycle to the RESP cycle.
    function automatic rsp_t ref_rsp(input logic id, input op_t op, input int delay);
        rsp_t res;
        div_t d;
        res    = '0;
        res.id = id;
        if (TO_EN && (delay == 0 || delay > T_CYC)) begin
            res.to  = 1'b1;
            res.lat = 8'(T_CYC + 1);
        end else begin
            d       = div_fn(op);
            res.q   = d.q;
            res.r   = d.r;
            res.ov  = d.ov;
            res.dbz = d.dbz;
            res.lat = 8'(delay + 2);
        end
        return res;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.dvd = 10'($urandom);
        op.dvs = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
        return op;
    endfunction

    task automatic step();
        rsp_t       e;
        div_t       d;
        logic [1:0] lv;
        logic       exp_win;
        @(negedge clk);
        cycle++;
        div_done = 1'b0;
        div_ov   = 1'b0;
        div_dbz  = 1'b0;
        div_dout = '0;
        if (rst) begin
            m_phase  = 0;
            prev_ack = 2'b00;
            return;
        end

        lv = {req1, req0};
        if (ack0 || ack1) begin
            exp_win = (lv == 2'b11) ? (have_last ? ~last_id : 1'b0) : lv[1];
            check("ack_onehot", 32'(ack0 ^ ack1), 32'd1);
            check("ack_single_cycle", 32'(prev_ack), 32'd0);
            check("grant_id", 32'(ack1), 32'(exp_win));
            grant_log.push_back(int'(ack1));
            if (ack1 && op_q1.size() > 0)       cur_op = op_q1[0];
            else if (!ack1 && op_q0.size() > 0) cur_op = op_q0[0];
            exp_q.push_back(ref_rsp(ack1, cur_op, done_delay));
        end

        if (div_start) begin
            check("start_with_ack", 32'(ack0 | ack1), 32'd1);
            check("div_word_hi", 32'(div_data), 32'(cur_op.dvd[9:5]));
            m_op.dvd[9:5] = div_data;
            m_phase       = 1;
        end else begin
            case (m_phase)
                1: begin
                    check("div_word_lo", 32'(div_data), 32'(cur_op.dvd[4:0]));
                    m_op.dvd[4:0] = div_data;
                    m_phase       = 2;
                end
                2: begin
                    check("div_word_divisor", 32'(div_data), 32'(cur_op.dvs));
                    m_op.dvs  = div_data;
                    m_phase   = 3;
                    m_cnt     = 0;
                    div_cycle = cycle;
                end
                3: begin
                    check("div_word_idle", 32'(div_data), 32'd0);
                    m_cnt++;
                    if (done_delay != 0 && m_cnt == done_delay) begin
                        d        = div_fn(m_op);
                        div_done = 1'b1;
                        div_dout = d.q;
                        div_ov   = d.ov;
                        div_dbz  = d.dbz;
                        m_rem    = d.r;
                        m_phase  = 4;
                    end
                end
                4: begin
                    check("div_word_idle", 32'(div_data), 32'd0);
                    div_dout = m_rem;
                    m_phase  = 0;
                end
                default: check("div_word_idle", 32'(div_data), 32'd0);
            endcase
        end

        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_quot", 32'(rsp_quot), 32'(e.q));
                check("rsp_rem", 32'(rsp_rem), 32'(e.r));
                check("rsp_ov", 32'(rsp_ov), 32'(e.ov));
                check("rsp_dbz", 32'(rsp_dbz), 32'(e.dbz));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                check("rsp_latency", 32'(cycle - div_cycle), 32'(e.lat));
                have_last = 1'b1;
                last_id   = e.id;
            end
        end
        prev_ack = {ack1, ack0};

        if (ack0 && op_q0.size() > 0) void'(op_q0.pop_front());
        if (ack1 && op_q1.size() > 0) void'(op_q1.pop_front());
        if (op_q0.size() > 0) begin
            req0 = 1'b1; dividend0 = op_q0[0].dvd; divisor0 = op_q0[0].dvs;
        end else begin
            req0 = 1'b0; dividend0 = 10'($urandom); divisor0 = 5'($urandom);
        end
        if (op_q1.size() > 0) begin
            req1 = 1'b1; dividend1 = op_q1[0].dvd; divisor1 = op_q1[0].dvs;
        end else begin
            req1 = 1'b0; dividend1 = 10'($urandom); divisor1 = 5'($urandom);
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((op_q0.size() + op_q1.size() + exp_q.size()) != 0 && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_in_budget", 32'(n < max_cycles), 32'd1);
        repeat (2) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) step();
        rst       = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
        m_phase   = 0;
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({ack1, ack0, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_ov, rsp_dbz,
                    rsp_timeout, div_start, div_data});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int         n;
        logic [1:0] sel;

        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;

        // 100 / 7: words 3, 4, 7 and result q=14 r=2.
        done_delay = 3;
        op_q0.push_back('{dvd: 10'd100, dvs: 5'd7});
        drain(100);

        // Simultaneous requests after reset alternate starting with requester 0.
        pulse_reset();
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            op_q0.push_back(rand_op());
            op_q1.push_back(rand_op());
        end
        done_delay = 2;
        drain(300);
        check("fair_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("fair_grant_order", 32'(grant_log[i]), 32'(i % 2));

        // Overflow on requester 1, then divide-by-zero on requester 0.
        done_delay = 4;
        op_q1.push_back('{dvd: 10'd1000, dvs: 5'd3});
        drain(100);
        op_q0.push_back('{dvd: 10'd50, dvs: 5'd0});
        drain(100);

        // Asynchronous reset while the divider is busy aborts without a response.
        done_delay = 0;
        op_q0.push_back('{dvd: 10'd300, dvs: 5'd9});
        n = 0;
        while (!(m_phase == 3 && m_cnt >= 3) && n < 50) begin
            step();
            n++;
        end
        check("reached_wait_done", 32'(m_phase), 32'd3);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", all_outputs(), 32'd0);
        repeat (2) step();
        rst       = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
        m_phase   = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
        end
        done_delay = 2;
        op_q0.push_back('{dvd: 10'd300, dvs: 5'd9});
        drain(100);

`ifdef DIV_ARB_TIMEOUT_EN
        // Never done: watchdog. Done on the last allowed cycle: normal. One cycle late: watchdog.
        done_delay = 0;
        op_q1.push_back('{dvd: 10'd77, dvs: 5'd5});
        drain(100);
        done_delay = T_CYC;
        op_q0.push_back('{dvd: 10'd77, dvs: 5'd5});
        drain(100);
        done_delay = T_CYC + 1;
        op_q0.push_back('{dvd: 10'd900, dvs: 5'd31});
        drain(100);
`endif

        // Requester 0 holds req high across four back-to-back transactions.
        done_delay = 1;
        for (int i = 0; i < 4; i++) op_q0.push_back(rand_op());
        drain(300);

        // Randomized traffic from both requesters with varying divider latency.
        for (int i = 0; i < 16; i++) begin
            done_delay = int'($urandom_range(6, 1));
            sel        = 2'($urandom_range(3, 1));
            if (sel[0]) op_q0.push_back(rand_op());
            if (sel[1]) op_q1.push_back(rand_op());
            drain(200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 10-by-5 serial divider between two requesters.
- Each requester presents a full operand pair in parallel: 10-bit dividend, 5-bit divisor.
- The block runs the divider's 5-bit serial load protocol, waits for completion, then collects quotient and remainder.
- Returns a tagged result on a shared response bus. Sits between the divider top and the client logic.

Parameters:
- TIMEOUT_CYCLES, 63: maximum cycles in WAIT_DONE before the watchdog aborts. Used only with DIV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request; held until ack0
- dividend0  in  10  requester 0 dividend
- divisor0  in  5  requester 0 divisor
- ack0  out  1  one-cycle pulse: requester 0 operands captured
- req1, dividend1, divisor1, ack1: same as above, requester 1
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  1  requester that owns the result
- rsp_quot  out  5  quotient
- rsp_rem  out  5  remainder
- rsp_ov  out  1  divider overflow flag
- rsp_dbz  out  1  divide-by-zero flag
- rsp_timeout  out  1  watchdog abort flag
- div_start  out  1  divider start, high during first load word
- div_data  out  5  serial operand word to divider
- div_done  in  1  divider completion pulse
- div_ov  in  1  divider overflow, valid with div_done
- div_dbz  in  1  divider divide-by-zero, valid with div_done
- div_dout  in  5  divider result word: quotient with div_done, remainder the following cycle

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - State = IDLE.
  - Round-robin pointer = 0 (requester 0 wins the first tie).
  - Reset asserted mid-operation aborts the transaction. No rsp_valid is produced, and the requester is not re-served unless it asserts a new request.
- States: IDLE, LOAD_HI, LOAD_LO, LOAD_DIV, WAIT_DONE, READ_REM, RESP.
- IDLE:
  - On any req, select the winner and latch its operands and id.
  - Both requests high: grant the requester that is not the last served.
  - Go to LOAD_HI.
- LOAD_HI:
  - ackN = 1 for the winner.
  - div_start = 1, div_data = dividend[9:5].
- LOAD_LO: div_data = dividend[4:0], div_start = 0.
- LOAD_DIV: div_data = divisor. Go to WAIT_DONE.
- WAIT_DONE:
  - div_data = 0.
  - On div_done, capture div_dout as quotient plus div_ov and div_dbz. Go to READ_REM.
- READ_REM: capture div_dout as remainder. Go to RESP.
- RESP:
  - rsp_valid = 1 with all rsp_* fields.
  - Update pointer to the served id. Return to IDLE.
- rsp_* fields hold their values until the next RESP.
- div_data = 0 in every state other than the three load states.
- Requester protocol:
  - req must stay high until ack.
  - req still high the cycle after ack counts as a new request.
  - Operands are sampled only at the IDLE grant edge; later changes are ignored.
- Requests arriving in non-IDLE states wait; there is no queue beyond the req level.
- Fairness: back-to-back requests from both requesters alternate strictly.
- Latency: req sampled in IDLE → rsp_valid = 5 + (cycles in WAIT_DONE) cycles.
- div_done outside WAIT_DONE is ignored.

Optional Feature:
- Macro: DIV_ARB_TIMEOUT_EN.
- With the macro:
  - A WAIT_DONE cycle counter is cleared on entry.
  - If it reaches TIMEOUT_CYCLES without div_done, go to RESP with rsp_timeout = 1, rsp_quot = rsp_rem = 0, rsp_ov = rsp_dbz = 0.
  - div_done in the same cycle as expiry wins, giving a normal result.
- Without the macro: no counter; rsp_timeout is tied to 0 and WAIT_DONE waits indefinitely.

Decomposition:
- Package div_arb_pkg:
  - State enum.
  - Constants DIVIDEND_W = 10, DIVISOR_W = 5, WORD_W = 5.
  - Default TIMEOUT_CYCLES.
- Sub-module rr_arbiter2:
  - Inputs: 2-bit request, last-served pointer.
  - Output: one-hot grant plus id.
  - Combinational, instantiated once.

Test Plan:
- req0, 100/7; divider model returns done with q = 14, r = 2 → ack0 pulse in LOAD_HI; div_data sequence 3, 4, 7; rsp_valid with id = 0, quot = 14, rem = 2, ov = 0, dbz = 0.
- req0 and req1 in the same cycle, three rounds each → grant order 0, 1, 0, 1, 0, 1; each rsp_id matches its operands.
- req1, 1000/3; model flags ov → rsp_ov = 1, rsp_id = 1. req0, 50/0 → rsp_dbz = 1.
- rst asserted during WAIT_DONE → all outputs 0 immediately; no rsp_valid; the next req0 is served normally from LOAD_HI.
- With DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, model never sends done → rsp_valid with rsp_timeout = 1 exactly 8 cycles after WAIT_DONE entry. Done arriving on cycle 8 → normal result with rsp_timeout = 0.
- req held high continuously by requester 0 while requester 1 idle → back-to-back transactions; each ack0 pulse is exactly one cycle.
